// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

  // Fetch controller states.
  //   REQ  : presenting pc_in to instruction memory
  //   WAIT : one request accepted, waiting for its response
  //   DROP : a flush orphaned the outstanding request; swallow its response
  //   FULL : response parked in the skid buffer while decode is stalled
  typedef enum logic [1:0] {
    REQ  = 2'd0,
    WAIT = 2'd1,
    DROP = 2'd2,
    FULL = 2'd3
  } fetch_state_t;

  // Distance between sequential instructions.
  localparam int unsigned PC_INCR = 4;

  // Contents of an empty IF/ID slot.
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

endpackage

// File: rtl/fetch_skid_reg.sv
// One-entry holding register for a fetched {instr, pc} pair. It catches a
// memory response that arrives while decode is stalled with a full IF/ID
// slot. Clear beats load, and load beats drain.
module fetch_skid_reg #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              load,
  input  logic              drain,
  input  logic              clear,
  input  logic [DATA_W-1:0] instr_d,
  input  logic [ADDR_W-1:0] pc_d,
  output logic              valid,
  output logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] pc
);

  // Occupancy flag: set on load, dropped on drain or clear.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      valid <= 1'b0;
    end else if (clear) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
    end else if (drain) begin
      valid <= 1'b0;
    end
  end

  // Payload is captured only on load and otherwise holds.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      instr <= '0;
      pc    <= '0;
    end else if (!clear && load) begin
      instr <= instr_d;
      pc    <= pc_d;
    end
  end

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage between the PC register and the IF/ID boundary.
//
// Handshake rules used on every channel of this block:
//   - A request transfers on a rising edge where valid && ready are both high.
//   - Once imem_req_valid is raised (without a flush) it stays high with a
//     stable imem_req_addr until the edge on which imem_req_ready is seen.
//   - At most one request is outstanding; imem_rsp_valid is a one-cycle pulse
//     arriving at least one cycle after acceptance and is never back-pressured.
//   - The IF/ID slot is consumed on any edge where if_valid && !id_stall.
module instruction_fetch
  import fetch_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] pc_in,
  output logic              pc_advance,
  output logic              imem_req_valid,
  output logic [ADDR_W-1:0] imem_req_addr,
  input  logic              imem_req_ready,
  input  logic              imem_rsp_valid,
  input  logic [DATA_W-1:0] imem_rsp_data,
  input  logic              flush,
  input  logic              id_stall,
  output logic              if_valid,
  output logic [DATA_W-1:0] if_instr,
  output logic [ADDR_W-1:0] if_pc,
  output logic [ADDR_W-1:0] if_pc_plus4,
  output logic [1:0]        fsm_state
);

  fetch_state_t      state;
  fetch_state_t      state_next;
  logic [ADDR_W-1:0] pending_pc;

  logic              req_open;
  logic              fire;
  logic              slot_load_rsp;
  logic              slot_load_skid;
  logic              skid_load;
  logic              skid_drain;
  logic              skid_valid;
  logic [DATA_W-1:0] skid_instr;
  logic [ADDR_W-1:0] skid_pc;

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= REQ;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic plus the per-state load/steer strobes.
  always_comb begin
    state_next     = state;
    req_open       = 1'b0;
    slot_load_rsp  = 1'b0;
    slot_load_skid = 1'b0;
    skid_load      = 1'b0;
    skid_drain     = 1'b0;
    case (state)
      REQ: begin
        // A flush suppresses the request so the redirected pc_in goes out
        // next cycle instead of the stale one.
        req_open = !flush;
        if (!flush && imem_req_ready) begin
          state_next = WAIT;
        end
      end
      WAIT: begin
        if (imem_rsp_valid) begin
          if (flush) begin
            state_next = REQ;
          end else if (!if_valid || !id_stall) begin
            slot_load_rsp = 1'b1;
            state_next    = REQ;
          end else begin
            skid_load  = 1'b1;
            state_next = FULL;
          end
        end else if (flush) begin
          state_next = DROP;
        end
      end
      DROP: begin
        // The orphaned response is discarded; later flushes change nothing.
        if (imem_rsp_valid) begin
          state_next = REQ;
        end
      end
      FULL: begin
        if (flush) begin
          state_next = REQ;
        end else if (!id_stall) begin
          skid_drain     = 1'b1;
          slot_load_skid = skid_valid;
          state_next     = REQ;
        end
      end
      default: begin
        state_next = REQ;
      end
    endcase
  end

  // Request channel and PC advance; both are held low while reset is active.
  always_comb begin
    imem_req_valid = req_open && reset;
    imem_req_addr  = pc_in;
    fire           = imem_req_valid && imem_req_ready;
    pc_advance     = fire;
    fsm_state      = state;
  end

  // Remember which PC the outstanding request belongs to.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pending_pc <= '0;
    end else if (fire) begin
      pending_pc <= pc_in;
    end
  end

  fetch_skid_reg #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_skid (
    .clock   (clock),
    .reset   (reset),
    .load    (skid_load),
    .drain   (skid_drain),
    .clear   (flush),
    .instr_d (imem_rsp_data),
    .pc_d    (pending_pc),
    .valid   (skid_valid),
    .instr   (skid_instr),
    .pc      (skid_pc)
  );

  // IF/ID slot: flush wins, then a load, then consumption empties it.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      if_valid    <= 1'b0;
      if_instr    <= DATA_W'(NOP_INSTR);
      if_pc       <= '0;
      if_pc_plus4 <= '0;
    end else if (flush) begin
      if_valid <= 1'b0;
    end else if (slot_load_rsp) begin
      if_valid    <= 1'b1;
      if_instr    <= imem_rsp_data;
      if_pc       <= pending_pc;
      if_pc_plus4 <= pending_pc + ADDR_W'(PC_INCR);
    end else if (slot_load_skid) begin
      if_valid    <= 1'b1;
      if_instr    <= skid_instr;
      if_pc       <= skid_pc;
      if_pc_plus4 <= skid_pc + ADDR_W'(PC_INCR);
    end else if (!id_stall) begin
      if_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch. Inputs change just after the falling
// edge; registered outputs are sampled at the falling edge, combinational
// outputs 1 ns after the inputs are driven.
module tb_instruction_fetch;
  import fetch_pkg::*;

  logic        clock;
  logic        reset;
  logic [31:0] pc_in;
  logic        pc_advance;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        flush;
  logic        id_stall;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic [31:0] if_pc_plus4;
  logic [1:0]  fsm_state;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] exp_q[$];

  instruction_fetch #(.ADDR_W(32), .DATA_W(32)) dut (
    .clock          (clock),
    .reset          (reset),
    .pc_in          (pc_in),
    .pc_advance     (pc_advance),
    .imem_req_valid (imem_req_valid),
    .imem_req_addr  (imem_req_addr),
    .imem_req_ready (imem_req_ready),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .flush          (flush),
    .id_stall       (id_stall),
    .if_valid       (if_valid),
    .if_instr       (if_instr),
    .if_pc          (if_pc),
    .if_pc_plus4    (if_pc_plus4),
    .fsm_state      (fsm_state)
  );

  // Clock and watchdog.
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic settle();
    #1;
  endtask

  logic [31:0] got_w;

  initial begin
    reset          = 1'b1;
    pc_in          = 32'h0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    flush          = 1'b0;
    id_stall       = 1'b0;
    #3 reset = 1'b0;
    #1;
    check("rst_state", fsm_state, REQ);
    check("rst_if_valid", if_valid, 1'b0);
    check("rst_req_valid", imem_req_valid, 1'b0);
    check("rst_pc_adv", pc_advance, 1'b0);
    check("rst_if_pc_plus4", if_pc_plus4, 32'h0);
    @(negedge clock);
    reset = 1'b1;
    settle();
    check("post_rst_req_valid", imem_req_valid, 1'b1);
    check("post_rst_req_addr", imem_req_addr, 32'h0);

    // Basic fetch with one-cycle memory.
    pc_in = 32'h0040_0000; imem_req_ready = 1'b1; settle();
    check("t1_pc_adv_fire", pc_advance, 1'b1);
    check("t1_req_addr", imem_req_addr, 32'h0040_0000);
    cyc();
    imem_req_ready = 1'b0; pc_in = 32'h0040_0004; settle();
    check("t1_wait_state", fsm_state, WAIT);
    check("t1_wait_pc_adv", pc_advance, 1'b0);
    check("t1_wait_req_valid", imem_req_valid, 1'b0);
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'h2008_0005;
    cyc();
    imem_rsp_valid = 1'b0; settle();
    check("t1_if_valid", if_valid, 1'b1);
    check("t1_if_instr", if_instr, 32'h2008_0005);
    check("t1_if_pc", if_pc, 32'h0040_0000);
    check("t1_if_pc_plus4", if_pc_plus4, 32'h0040_0004);
    check("t1_back_to_req", fsm_state, REQ);

    // Memory not ready for three cycles: request held steady.
    for (int i = 0; i < 3; i++) begin
      settle();
      check("t2_hold_req_valid", imem_req_valid, 1'b1);
      check("t2_hold_addr", imem_req_addr, 32'h0040_0004);
      check("t2_hold_no_adv", pc_advance, 1'b0);
      cyc();
      if (i == 0) check("t2_slot_consumed", if_valid, 1'b0);
    end
    imem_req_ready = 1'b1; settle();
    check("t2_fire_adv", pc_advance, 1'b1);
    cyc();
    imem_req_ready = 1'b0; pc_in = 32'h0040_0008;

    // Fill the slot, stall decode, then a second response goes to the skid.
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'h1111_0002;
    cyc();
    imem_rsp_valid = 1'b0; id_stall = 1'b1;
    check("t3_slot_first", if_instr, 32'h1111_0002);
    imem_req_ready = 1'b1; settle();
    check("t3_fire_while_stalled", pc_advance, 1'b1);
    cyc();
    imem_req_ready = 1'b0; pc_in = 32'h0040_000C;
    check("t3_slot_held_valid", if_valid, 1'b1);
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'hAAAA_0001;
    cyc();
    imem_rsp_valid = 1'b0; imem_req_ready = 1'b1; settle();
    check("t3_full_state", fsm_state, FULL);
    check("t3_full_no_req", imem_req_valid, 1'b0);
    check("t3_full_no_adv", pc_advance, 1'b0);
    check("t3_slot_unchanged", if_instr, 32'h1111_0002);
    cyc();
    check("t3_still_full", fsm_state, FULL);
    imem_req_ready = 1'b0; id_stall = 1'b0;
    cyc();
    check("t3_skid_to_slot", if_instr, 32'hAAAA_0001);
    check("t3_skid_valid", if_valid, 1'b1);
    check("t3_skid_pc", if_pc, 32'h0040_0008);
    check("t3_skid_pc_plus4", if_pc_plus4, 32'h0040_000C);
    check("t3_after_full_req", fsm_state, REQ);
    cyc();
    check("t3_drained", if_valid, 1'b0);

    // Flush while waiting, orphan response two cycles later.
    imem_req_ready = 1'b1;
    cyc();
    imem_req_ready = 1'b0; flush = 1'b1;
    cyc();
    flush = 1'b0; pc_in = 32'h0040_0100; settle();
    check("t4_drop_state", fsm_state, DROP);
    check("t4_drop_no_req", imem_req_valid, 1'b0);
    cyc();
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'hDEAD_BEEF;
    cyc();
    imem_rsp_valid = 1'b0; settle();
    check("t4_orphan_dropped", if_valid, 1'b0);
    check("t4_req_state", fsm_state, REQ);
    check("t4_redirect_addr", imem_req_addr, 32'h0040_0100);

    // Flush in REQ suppresses the request; then fetch the wrapping PC.
    flush = 1'b1; imem_req_ready = 1'b1; settle();
    check("t5_flush_no_req", imem_req_valid, 1'b0);
    check("t5_flush_no_adv", pc_advance, 1'b0);
    cyc();
    flush = 1'b0; pc_in = 32'hFFFF_FFFC; settle();
    check("t5_stay_req", fsm_state, REQ);
    check("t5_wrap_fire", pc_advance, 1'b1);
    cyc();
    imem_req_ready = 1'b0; pc_in = 32'h0000_0000;
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'h1234_5678;
    cyc();
    imem_rsp_valid = 1'b0; id_stall = 1'b1;
    check("t5_wrap_pc", if_pc, 32'hFFFF_FFFC);
    check("t5_wrap_plus4", if_pc_plus4, 32'h0000_0000);

    // Flush coincident with a response while the stalled slot is full.
    imem_req_ready = 1'b1;
    cyc();
    imem_req_ready = 1'b0; pc_in = 32'h0000_0004;
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'h7777_0007; flush = 1'b1;
    cyc();
    imem_rsp_valid = 1'b0; flush = 1'b0; id_stall = 1'b0;
    check("t6_flush_rsp_if_valid", if_valid, 1'b0);
    check("t6_flush_rsp_state", fsm_state, REQ);
    cyc();
    check("t6_still_empty", if_valid, 1'b0);

    // Reset asserted mid-WAIT with the slot valid.
    imem_req_ready = 1'b1;
    cyc();
    imem_req_ready = 1'b0; pc_in = 32'h0000_0008;
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'h5555_0003;
    cyc();
    imem_rsp_valid = 1'b0; id_stall = 1'b1; imem_req_ready = 1'b1;
    cyc();
    imem_req_ready = 1'b0;
    check("t7_pre_state", fsm_state, WAIT);
    check("t7_pre_if_valid", if_valid, 1'b1);
    imem_req_ready = 1'b1; reset = 1'b0; settle();
    check("t7_rst_if_valid", if_valid, 1'b0);
    check("t7_rst_if_instr", if_instr, 32'h0);
    check("t7_rst_if_pc", if_pc, 32'h0);
    check("t7_rst_plus4", if_pc_plus4, 32'h0);
    check("t7_rst_req_valid", imem_req_valid, 1'b0);
    check("t7_rst_pc_adv", pc_advance, 1'b0);
    check("t7_rst_state", fsm_state, REQ);
    pc_in = 32'h0; imem_req_ready = 1'b0;
    cyc();
    reset = 1'b1; id_stall = 1'b0; settle();
    check("t7_rel_req_valid", imem_req_valid, 1'b1);
    check("t7_rel_req_addr", imem_req_addr, 32'h0);

    // Back-to-back stream at one instruction per two cycles.
    for (int i = 0; i < 4; i++) begin
      imem_req_ready = 1'b1; settle();
      check("t8_fire", pc_advance, 1'b1);
      cyc();
      imem_req_ready = 1'b0; pc_in = pc_in + 32'd4;
      imem_rsp_valid = 1'b1; imem_rsp_data = 32'h0100_0000 + 32'(i);
      exp_q.push_back(32'h0100_0000 + 32'(i));
      cyc();
      imem_rsp_valid = 1'b0;
      check("t8_valid", if_valid, 1'b1);
      if (exp_q.size() != 0) begin
        got_w = exp_q.pop_front();
        check("t8_stream_instr", if_instr, got_w);
      end
      check("t8_stream_pc", if_pc, 32'(i) * 32'd4);
    end
    check("t8_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Fetch stage between the program counter register and the IF/ID boundary.
- Takes the current PC and issues one read to instruction memory over a valid/ready request channel, with at most one request outstanding.
- Returns the instruction, its PC and PC+4 to decode through a registered, stallable, flushable output slot with a one-entry skid buffer.
- Tells the PC register when to advance.

## Interface
Parameters:
- ADDR_W, 32, PC/address width
- DATA_W, 32, instruction width

Ports:
- clock  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low; 0 forces the reset state immediately
- pc_in  in  ADDR_W  current PC from the program counter register
- pc_advance  out  1  combinational; high in the cycle a request is accepted; PC loads its next value on that edge
- imem_req_valid  out  1  request valid
- imem_req_addr  out  ADDR_W  request address, equal to pc_in
- imem_req_ready  in  1  memory accepts request
- imem_rsp_valid  in  1  response valid, single-cycle pulse, arrives ≥1 cycle after acceptance
- imem_rsp_data  in  DATA_W  instruction word
- flush  in  1  branch/jump redirect; discard all fetched and in-flight work
- id_stall  in  1  decode cannot accept this cycle
- if_valid  out  1  IF/ID slot holds a valid instruction
- if_instr  out  DATA_W  instruction
- if_pc  out  ADDR_W  PC of if_instr
- if_pc_plus4  out  ADDR_W  if_pc + 4

## Operation
FSM states are REQ, WAIT, DROP and FULL.
- **REQ**
  - imem_req_valid = !flush.
  - On fire (valid && ready): pending_pc <= pc_in, pc_advance = 1, go to WAIT.
  - flush in REQ: no request this cycle, stay REQ, so the redirected pc_in is fetched next cycle.
- **WAIT**
  - On rsp_valid && !flush: if the slot is free or consumed this cycle (!if_valid || !id_stall), load the slot and go to REQ. Otherwise write the skid buffer and go to FULL.
  - rsp_valid && flush: drop the response, go to REQ.
  - flush without response: go to DROP.
- **DROP**
  - Wait for the orphan response, discard it, go to REQ.
  - Further flushes keep DROP.
- **FULL**
  - No requests.
  - When !id_stall: skid moves to the slot, go to REQ.
  - flush: clear skid and slot, go to REQ.

IF/ID slot rules:
- flush clears if_valid in every state; flush wins over any simultaneous load.
- if_valid drops when consumed (!id_stall) and nothing loads that cycle.
- Slot contents hold while id_stall && if_valid.

Arithmetic and memory rules:
- if_pc_plus4 = pending_pc + 4, modulo 2^ADDR_W; 32'hFFFF_FFFC wraps to 0.
- imem_rsp_valid outside WAIT/DROP is ignored.

## Timing
Reset values (reset = 0):
- state = REQ.
- if_valid, imem_req_valid (gated by reset), pc_advance = 0.
- if_instr, if_pc, if_pc_plus4, pending_pc and skid = 0.
- Reset asserted mid-transaction abandons it. Memory must be reset by the same signal, so no stale response arrives.

Latency and throughput:
- Request accepted at cycle N, response at cycle M ≥ N+1, if_valid high from cycle M+1.
- Peak throughput is 1 instruction per 2 cycles with single-cycle memory.

Handshake:
- imem_req_valid, once raised without flush, holds with a stable address until ready.
- pc_in changes only after pc_advance or a redirect.

Stall: a response during a stall lands in the skid buffer. No response is lost; none is duplicated.

## Structure
- Shared package `fetch_pkg`:
  - fetch_state_t enum {REQ, WAIT, DROP, FULL}
  - PC_INCR = 4
  - NOP_INSTR = 32'h0000_0000
- Sub-module `fetch_skid_reg`: one-entry holding register for {instr, pc}, with load, drain and clear inputs and a valid output.

## Test plan
- Reset low mid-WAIT with if_valid = 1 → all outputs 0 immediately. After release, first request addr = pc_in = 32'h0000_0000.
- pc_in 32'h0040_0000, ready = 1, rsp 1 cycle later with data 32'h2008_0005 → pc_advance one cycle; next cycle if_valid = 1, if_instr 32'h2008_0005, if_pc 32'h0040_0000, if_pc_plus4 32'h0040_0004.
- ready held 0 for 3 cycles → req_valid stays 1 and addr stable; pc_advance only on the fire cycle.
- id_stall = 1 with slot full, response 32'hAAAA_0001 arrives → FULL, no new request. Release stall → slot shows 32'hAAAA_0001 next cycle, then REQ.
- flush in WAIT, response 2 cycles later → DROP; response discarded, if_valid = 0. Next request uses the redirected pc_in 32'h0040_0100.
- pending_pc 32'hFFFF_FFFC → if_pc_plus4 = 32'h0000_0000. Flush coincident with response in WAIT → if_valid stays 0.
